wb_slave_sequencer: RTL and testbench
=====================================

# wb_slave_sequencer

Registered Wishbone transaction sequencer between the Caravel host port and the nebula_ii slaves (GPIO control, LA control, team designs). It decodes each host transaction to exactly one slave slot and drives that slot's strobe until it acks. It returns the slave's read data and converts hung or unmapped accesses into a guaranteed error response via a timeout watchdog. It is the sequential front end of the user-area bus; the per-team wrappers sit behind it.

## Interface
- NUM_TEAMS, 1: team design slots, legal range 1..14.
- TIMEOUT_CYCLES, 255: cycles a selected slave may take before forced error response, 2..255.
- NSLOTS, NUM_TEAMS+2: localparam, not overridable.

- wb_clk_i  in  1  sole clock, all logic rising-edge.
- wb_rst_ni  in  1  asynchronous active-low reset; top drives ~wb_rst_i.
- wbs_cyc_i  in  1  host cycle.
- wbs_stb_i  in  1  host strobe.
- wbs_adr_i  in  32  host address.
- wbs_ack_o  out  1  host ack, registered, one-cycle pulse.
- wbs_dat_o  out  32  host read data, valid only while wbs_ack_o=1, else 0.
- slv_stb_o  out  NSLOTS  one-hot slave strobe; bit0 GPIO ctrl, bit1 LA ctrl, bit 2+n team n+1.
- slv_ack_i  in  NSLOTS  slave acks.
- slv_dat_i  in  32*NSLOTS  slave read data, slot s at [32*s+31:32*s].
- adr_truncated_o  out  32  {16'h0, wbs_adr_i[15:0]}, combinational.
- timeout_o  out  1  one-cycle pulse on forced timeout response.
- err_cnt_o  out  8  saturating count of timeouts plus unmapped accesses.

## Operation
- Decode: slot = wbs_adr_i[19:16]. A slot is mapped iff slot < NSLOTS. Upper address bits are ignored.
- FSM states: IDLE, ACTIVE, RESP.
- IDLE: on cyc&stb:
  - mapped slot: latch the slot, clear the timer, go to ACTIVE.
  - unmapped slot: load data 32'hDEAD_BEEF, increment err_cnt, go to RESP.
- ACTIVE: slv_stb_o[slot]=1, all other strobe bits 0; the timer increments each cycle.
  - slv_ack_i[slot]=1: capture the slave's data, go to RESP.
  - Otherwise, timer == TIMEOUT_CYCLES-1: load 32'hDEAD_BEEF, pulse timeout_o, increment err_cnt, go to RESP.
  - cyc_i=0 (host abort): go to IDLE with no ack and no error count.
- RESP: wbs_ack_o=1 and wbs_dat_o=captured data for exactly one cycle, then IDLE unconditionally.
- Acks on non-selected slots are ignored in every state. Any slv_ack_i in IDLE or RESP is ignored.
- Ack and timeout in the same cycle: the ack wins, real data is returned, and there is no timeout_o pulse.
- err_cnt_o saturates at 8'hFF. Only reset clears it.
- Writes and reads are sequenced identically; write data and we go to the slaves directly, not through this block.

## Timing
- Reset (async assert, sync release): state IDLE, wbs_ack_o=0, wbs_dat_o=0, slv_stb_o=0, timeout_o=0, err_cnt_o=0, timer=0.
- Reset mid-transaction drops the strobe immediately. No ack is ever issued for that transaction.
- E0 is the edge where IDLE accepts a transaction. Count k = cycles after E0.
  - Mapped slot: ACTIVE spans k=0.. . A slave ack at k=j gives wbs_ack_o high at k=j+1. The minimum is k=1 for a combinational ack.
  - Timeout: ACTIVE at k=0..T-1 with T=TIMEOUT_CYCLES. wbs_ack_o and timeout_o are high at k=T.
  - Unmapped slot: wbs_ack_o high at k=0 (the cycle after the accept edge).
- The host drops stb on the edge that samples ack; that edge moves RESP to IDLE. Back-to-back transactions are therefore accepted at the earliest one cycle after the ack cycle.
- wbs_ack_o, wbs_dat_o, slv_stb_o and timeout_o are all flop outputs with no combinational path from inputs. adr_truncated_o is the only exception.

## Structure
- Shared package nebula_ii_pkg holds:
  - SLOT_GPIO=0, SLOT_LA=1, SLOT_TEAM_BASE=2;
  - WB_ERR_DATA=32'hDEAD_BEEF;
  - the FSM state encoding (2-bit IDLE/ACTIVE/RESP).
- Sub-module wb_timeout_counter: 8-bit clear/enable counter with an expired flag at TIMEOUT_CYCLES-1, instantiated once.
- The slot-to-data mux is inline; no other sub-modules.

## Test plan
- Read at adr 0x3001_0000, LA slave acks combinationally at k=0 with 0x1234_5678 -> wbs_ack_o at k=1 with data 0x1234_5678; slv_stb_o=3'b010 only during k=0.
- Slot 2 (team 1) never acks, TIMEOUT_CYCLES=8 -> wbs_ack_o and timeout_o at k=8, data 0xDEAD_BEEF, err_cnt_o=1.
- Unmapped adr 0x3005_0000 with NUM_TEAMS=1 -> ack at k=0, data 0xDEAD_BEEF, slv_stb_o stays 0, err_cnt_o increments.
- Stray ack on slot 0 while slot 2 is selected, then slot 2 acks at k=T-1 (coincident with timeout) -> real slot 2 data, no timeout_o, err_cnt_o unchanged.
- Host drops cyc at k=3; separately, reset asserted at k=3 -> both return to IDLE with no ack and strobes 0; the next transaction completes normally.
- 300 unmapped reads -> err_cnt_o holds at 8'hFF.

Source files
------------

// File: rtl/wb_slave_sequencer_pkg.sv
// Shared definitions for the nebula_ii user-area bus: slot map, error data word
// and the sequencer state encoding.
package nebula_ii_pkg;

   localparam int SLOT_GPIO      = 0;
   localparam int SLOT_LA        = 1;
   localparam int SLOT_TEAM_BASE = 2;

   localparam logic [31:0] WB_ERR_DATA = 32'hDEAD_BEEF;

   localparam int TIMER_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      RESP   = 2'd2
   } seq_state_t;

endpackage

// File: rtl/wb_slave_sequencer_if.sv
// Host-side Wishbone port of the user-area bus sequencer.
interface wb_slave_sequencer_if;

   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic [31:0] wbs_adr_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_cyc_i,
      output wbs_stb_i,
      output wbs_adr_i,
      input  wbs_ack_o,
      input  wbs_dat_o
   );

   modport slave (
      input  wbs_cyc_i,
      input  wbs_stb_i,
      input  wbs_adr_i,
      output wbs_ack_o,
      output wbs_dat_o
   );

endinterface

// File: rtl/wb_timeout_counter.sv
// Watchdog timer for a selected slave: clears while not in use, counts while
// enabled and flags the last cycle the slave is allowed before a forced error.
module wb_timeout_counter
   import nebula_ii_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [TIMER_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + TIMER_W'(1);
      end
   end

   assign expired = (count == TIMER_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_slave_sequencer.sv
// Wishbone front end of the user area: routes one host transaction at a time to
// a single slave slot and guarantees a response via unmapped/timeout errors.
module wb_slave_sequencer
   import nebula_ii_pkg::*;
#(
   parameter  int NUM_TEAMS      = 1,
   parameter  int TIMEOUT_CYCLES = 255,
   localparam int NSLOTS         = NUM_TEAMS + SLOT_TEAM_BASE
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_ni,
   wb_slave_sequencer_if.slave    wbs,
   output logic [NSLOTS-1:0]      slv_stb_o,
   input  logic [NSLOTS-1:0]      slv_ack_i,
   input  logic [32*NSLOTS-1:0]   slv_dat_i,
   output logic [31:0]            adr_truncated_o,
   output logic                   timeout_o,
   output logic [7:0]             err_cnt_o
);

   seq_state_t        state;
   logic [3:0]        sel_slot;
   logic [3:0]        dec_slot;
   logic              dec_mapped;
   logic [NSLOTS-1:0] dec_onehot;
   logic              ack_sel;
   logic [31:0]       dat_sel;
   logic              timer_clr;
   logic              timer_en;
   logic              timer_expired;
   logic              unused_adr;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign adr_truncated_o = {16'h0000, wbs.wbs_adr_i[15:0]};
   assign unused_adr      = ^wbs.wbs_adr_i[31:20];

   assign dec_slot   = wbs.wbs_adr_i[19:16];
   assign dec_mapped = ({1'b0, dec_slot} < 5'(NSLOTS));

   always_comb begin
      dec_onehot = '0;
      for (int s = 0; s < NSLOTS; s++) begin
         dec_onehot[s] = (dec_slot == 4'(s));
      end
   end

   // Only the latched slot's ack and data are visible; everything else is ignored.
   always_comb begin
      ack_sel = 1'b0;
      dat_sel = '0;
      for (int s = 0; s < NSLOTS; s++) begin
         if (sel_slot == 4'(s)) begin
            ack_sel = slv_ack_i[s];
            dat_sel = slv_dat_i[32*s +: 32];
         end
      end
   end

   assign timer_clr = (state != ACTIVE);
   assign timer_en  = (state == ACTIVE);

   wb_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (wb_clk_i),
      .rst_n   (wb_rst_ni),
      .clr     (timer_clr),
      .en      (timer_en),
      .expired (timer_expired)
   );

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state         <= IDLE;
         sel_slot      <= '0;
         slv_stb_o     <= '0;
         wbs.wbs_ack_o <= 1'b0;
         wbs.wbs_dat_o <= '0;
         timeout_o     <= 1'b0;
         err_cnt_o     <= '0;
      end else begin
         wbs.wbs_ack_o <= 1'b0;
         wbs.wbs_dat_o <= '0;
         timeout_o     <= 1'b0;
         case (state)
            IDLE: begin
               if (wbs.wbs_cyc_i && wbs.wbs_stb_i) begin
                  if (dec_mapped) begin
                     sel_slot  <= dec_slot;
                     slv_stb_o <= dec_onehot;
                     state     <= ACTIVE;
                  end else begin
                     wbs.wbs_ack_o <= 1'b1;
                     wbs.wbs_dat_o <= WB_ERR_DATA;
                     err_cnt_o     <= sat_inc(err_cnt_o);
                     state         <= RESP;
                  end
               end
            end
            ACTIVE: begin
               // A host that has dropped cyc is gone; never answer it.
               if (!wbs.wbs_cyc_i) begin
                  slv_stb_o <= '0;
                  state     <= IDLE;
               end else if (ack_sel) begin
                  slv_stb_o     <= '0;
                  wbs.wbs_ack_o <= 1'b1;
                  wbs.wbs_dat_o <= dat_sel;
                  state         <= RESP;
               end else if (timer_expired) begin
                  slv_stb_o     <= '0;
                  wbs.wbs_ack_o <= 1'b1;
                  wbs.wbs_dat_o <= WB_ERR_DATA;
                  timeout_o     <= 1'b1;
                  err_cnt_o     <= sat_inc(err_cnt_o);
                  state         <= RESP;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               slv_stb_o <= '0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_slave_sequencer.sv
// Scoreboard bench for wb_slave_sequencer: directed transactions push expected
// responses, a negedge monitor pops and compares them when the DUT acks.
module tb_wb_slave_sequencer;
   import nebula_ii_pkg::*;

   localparam int T  = 8;
   localparam int NS = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n;
   logic [NS-1:0]   slv_stb;
   logic [NS-1:0]   slv_ack;
   logic [NS-1:0]   auto_mask;
   logic [NS-1:0]   manual_ack;
   logic [32*NS-1:0] slv_dat;
   logic [31:0]     adr_trunc;
   logic            timeout;
   logic [7:0]      err_cnt;

   wb_slave_sequencer_if bus();

   assign slv_ack = (slv_stb & auto_mask) | manual_ack;
   assign slv_dat = {32'hC0DE_0002, 32'h1234_5678, 32'hA0A0_0000};

   wb_slave_sequencer #(
      .NUM_TEAMS      (1),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .wb_clk_i        (clk),
      .wb_rst_ni       (rst_n),
      .wbs             (bus),
      .slv_stb_o       (slv_stb),
      .slv_ack_i       (slv_ack),
      .slv_dat_i       (slv_dat),
      .adr_truncated_o (adr_trunc),
      .timeout_o       (timeout),
      .err_cnt_o       (err_cnt)
   );

   typedef struct {
      logic [31:0] data;
      logic        to;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int vectors     = 0;
   int miscompares = 0;
   int cyc_cnt     = 0;
   int exp_err     = 0;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Response monitor
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1) begin
         if (bus.wbs_ack_o) begin
            if (sb.size() == 0) begin
               check("unexpected_ack", 64'(bus.wbs_ack_o), 64'd0);
            end else begin
               e = sb.pop_front();
               check("resp_data", 64'(bus.wbs_dat_o), 64'(e.data));
               check("resp_timeout", 64'(timeout), 64'(e.to));
               check("resp_cycle", 64'(cyc_cnt), 64'(e.cyc));
            end
         end else if (timeout || bus.wbs_dat_o != 32'h0) begin
            check("idle_outputs", {31'h0, timeout, bus.wbs_dat_o}, 64'd0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_txn(input logic [31:0] adr, input bit expect_resp,
                            input logic [31:0] d, input bit to, input int k,
                            input logic [NS-1:0] exp_stb);
      bus.wbs_adr_i = adr;
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      #1;
      check("adr_truncated", 64'(adr_trunc), {32'h0, 16'h0, adr[15:0]});
      if (expect_resp) sb.push_back('{d, to, cyc_cnt + 1 + k});
      tick();
      check("stb_k0", 64'(slv_stb), 64'(exp_stb));
   endtask

   task automatic finish_txn();
      int n = 0;
      while (!bus.wbs_ack_o && n < 300) begin
         tick();
         n++;
      end
      check("ack_seen", 64'(bus.wbs_ack_o), 64'd1);
      tick();
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
   endtask

   task automatic la_read();
      auto_mask = 3'b010;
      begin_txn(32'h3001_0000, 1'b1, 32'h1234_5678, 1'b0, 1, 3'b010);
      tick();
      check("stb_k1", 64'(slv_stb), 64'd0);
      finish_txn();
      auto_mask = 3'b000;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, vectors %0d", vectors);
      $fatal(1);
   end

   initial begin
      rst_n         = 1'b0;
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_adr_i = 32'h0;
      auto_mask     = '0;
      manual_ack    = '0;
      #12;
      check("rst_ack", 64'(bus.wbs_ack_o), 64'd0);
      check("rst_dat", 64'(bus.wbs_dat_o), 64'd0);
      check("rst_stb", 64'(slv_stb), 64'd0);
      check("rst_timeout", 64'(timeout), 64'd0);
      check("rst_err_cnt", 64'(err_cnt), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();

      la_read();

      // Upper address bits must not affect decode
      auto_mask = 3'b010;
      begin_txn(32'hFFF1_ABCD, 1'b1, 32'h1234_5678, 1'b0, 1, 3'b010);
      finish_txn();
      auto_mask = 3'b000;

      begin_txn(32'h3002_0000, 1'b1, WB_ERR_DATA, 1'b1, T, 3'b100);
      finish_txn();
      exp_err = 1;
      check("err_after_timeout", 64'(err_cnt), 64'(exp_err));

      begin_txn(32'h3005_0000, 1'b1, WB_ERR_DATA, 1'b0, 0, 3'b000);
      finish_txn();
      exp_err = 2;
      check("err_after_unmapped", 64'(err_cnt), 64'(exp_err));

      // Stray slot-0 ack, then slot-2 ack coincident with the last allowed cycle
      begin_txn(32'h3002_0000, 1'b1, 32'hC0DE_0002, 1'b0, T, 3'b100);
      tick();
      tick();
      manual_ack = 3'b001;
      tick();
      manual_ack = 3'b000;
      repeat (T - 4) tick();
      manual_ack = 3'b100;
      tick();
      manual_ack = 3'b000;
      finish_txn();
      check("err_after_coincident", 64'(err_cnt), 64'(exp_err));

      // Host abort at k=3
      begin_txn(32'h3002_0000, 1'b0, 32'h0, 1'b0, 0, 3'b100);
      repeat (3) tick();
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      tick();
      check("abort_stb", 64'(slv_stb), 64'd0);
      repeat (T + 4) tick();
      check("err_after_abort", 64'(err_cnt), 64'(exp_err));
      la_read();

      // Reset asserted at k=3
      begin_txn(32'h3002_0000, 1'b0, 32'h0, 1'b0, 0, 3'b100);
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      check("midrst_stb", 64'(slv_stb), 64'd0);
      check("midrst_ack", 64'(bus.wbs_ack_o), 64'd0);
      check("midrst_err_cnt", 64'(err_cnt), 64'd0);
      exp_err = 0;
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      la_read();

      for (int i = 0; i < 300; i++) begin
         begin_txn({12'h300, 4'(3 + (i % 13)), 16'(i)}, 1'b1, WB_ERR_DATA, 1'b0, 0, 3'b000);
         finish_txn();
         exp_err = (exp_err < 255) ? exp_err + 1 : 255;
         check("err_cnt_sat", 64'(err_cnt), 64'(exp_err));
      end
      check("err_cnt_final", 64'(err_cnt), 64'hFF);

      repeat (3) tick();
      check("scoreboard_drained", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
